// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour widths, default key colour and RGB332->RGB444 expansion
package vga_pkg;

    localparam int RGB332_W = 8;
    localparam int RGB444_W = 12;

    localparam logic [RGB332_W-1:0] KEY_COLOR_DEFAULT = 8'hE3;

    // Replicate the top bits so full-scale 3/2-bit channels map to full-scale 4-bit channels.
    function automatic logic [RGB444_W-1:0] expand_332_444(input logic [RGB332_W-1:0] c);
        return {c[7:5], c[7], c[4:2], c[4], c[1:0], c[1:0]};
    endfunction

endpackage

// File: rtl/vga_layer_mixer_if.sv
// rtl/vga_layer_mixer_if.sv - pixel/sync bundle between vga_sync, layer generators and the mixer
interface vga_layer_mixer_if
    import vga_pkg::*;
#(
    parameter int N_LAYERS = 4,
    parameter int FCNT_W   = 8
);

    logic                         pixel_tick;
    logic                         video_on;
    logic                         hsync_in;
    logic                         vsync_in;
    logic [RGB332_W*N_LAYERS-1:0] layer_rgb;
    logic [N_LAYERS-1:0]          layer_en;
    logic [RGB332_W-1:0]          bg_rgb;
    logic                         hsync;
    logic                         vsync;
    logic [RGB444_W-1:0]          rgb;
    logic                         frame_start;
    logic [FCNT_W-1:0]            frame_cnt;

    modport master (
        output pixel_tick, video_on, hsync_in, vsync_in, layer_rgb, layer_en, bg_rgb,
        input  hsync, vsync, rgb, frame_start, frame_cnt
    );

    modport slave (
        input  pixel_tick, video_on, hsync_in, vsync_in, layer_rgb, layer_en, bg_rgb,
        output hsync, vsync, rgb, frame_start, frame_cnt
    );

endinterface

// File: rtl/layer_prio_sel.sv
// rtl/layer_prio_sel.sv - combinational priority select with per-layer transparency key
module layer_prio_sel
    import vga_pkg::*;
#(
    parameter int                  N_LAYERS  = 4,
    parameter logic [RGB332_W-1:0] KEY_COLOR = KEY_COLOR_DEFAULT
) (
    input  logic [RGB332_W*N_LAYERS-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]          layer_en,
    input  logic [RGB332_W-1:0]          bg_rgb,
    output logic [RGB332_W-1:0]          sel_rgb
);

    // Walk from lowest to highest priority so the lowest qualifying index wins.
    always_comb begin
        sel_rgb = bg_rgb;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i] && (layer_rgb[RGB332_W*i +: RGB332_W] != KEY_COLOR)) begin
                sel_rgb = layer_rgb[RGB332_W*i +: RGB332_W];
            end
        end
    end

endmodule

// File: rtl/vga_layer_mixer.sv
// rtl/vga_layer_mixer.sv - two-stage layer compositing pipeline with sync delay and frame logic
module vga_layer_mixer
    import vga_pkg::*;
#(
    parameter int                  N_LAYERS  = 4,
    parameter logic [RGB332_W-1:0] KEY_COLOR = KEY_COLOR_DEFAULT,
    parameter logic                SYNC_IDLE = 1'b0,
    parameter int                  FCNT_W    = 8
) (
    input  logic clk,
    input  logic reset,
    vga_layer_mixer_if.slave bus
);

    logic [RGB332_W-1:0] bg_shadow;
    logic [RGB332_W-1:0] mux_rgb;
    logic [RGB332_W-1:0] s1_rgb;
    logic                s1_video_on;
    logic                s1_hsync;
    logic                s1_vsync;
    logic [RGB444_W-1:0] rgb_q;
    logic                hsync_q;
    logic                vsync_q;
    logic                vsync_prev;
    logic                frame_start_q;
    logic [FCNT_W-1:0]   frame_cnt_q;
    logic                vsync_rise;

    layer_prio_sel #(
        .N_LAYERS  (N_LAYERS),
        .KEY_COLOR (KEY_COLOR)
    ) u_prio_sel (
        .layer_rgb (bus.layer_rgb),
        .layer_en  (bus.layer_en),
        .bg_rgb    (bg_shadow),
        .sel_rgb   (mux_rgb)
    );

    assign vsync_rise = bus.vsync_in & ~vsync_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_rgb      <= '0;
            s1_video_on <= 1'b0;
            s1_hsync    <= SYNC_IDLE;
            s1_vsync    <= SYNC_IDLE;
            rgb_q       <= '0;
            hsync_q     <= SYNC_IDLE;
            vsync_q     <= SYNC_IDLE;
        end else if (bus.pixel_tick) begin
            s1_rgb      <= mux_rgb;
            s1_video_on <= bus.video_on;
            s1_hsync    <= bus.hsync_in;
            s1_vsync    <= bus.vsync_in;
            rgb_q       <= s1_video_on ? expand_332_444(s1_rgb) : '0;
            hsync_q     <= s1_hsync;
            vsync_q     <= s1_vsync;
        end
    end

    // Frame logic runs every clk; the shadow only changes on a vsync rise so a frame never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_prev    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            bg_shadow     <= '0;
        end else begin
            vsync_prev    <= bus.vsync_in;
            frame_start_q <= vsync_rise;
            if (vsync_rise) begin
                bg_shadow   <= bus.bg_rgb;
                frame_cnt_q <= frame_cnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.rgb         = rgb_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb/tb_vga_layer_mixer.sv - directed self-checking bench for vga_layer_mixer
module tb_vga_layer_mixer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    vga_layer_mixer_if #(.N_LAYERS(4), .FCNT_W(8)) bus ();

    vga_layer_mixer #(
        .N_LAYERS  (4),
        .KEY_COLOR (8'hE3),
        .SYNC_IDLE (1'b0),
        .FCNT_W    (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic t);
        bus.pixel_tick = t;
        @(posedge clk);
        #1;
        bus.pixel_tick = 1'b0;
    endtask

    task automatic test_pipeline;
        bus.layer_rgb = {8'h00, 8'h00, 8'h00, 8'hE0};
        bus.layer_en  = 4'b0001;
        bus.video_on  = 1'b1;
        cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL pipe_1tick rgb=%h exp=%h", bus.rgb, 12'h000); end
        for (int i = 0; i < 3; i++) cycle(1'b0);
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL pipe_notick rgb=%h exp=%h", bus.rgb, 12'h000); end
        cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'hF00) begin n_err++; $display("FAIL pipe_2tick rgb=%h exp=%h", bus.rgb, 12'hF00); end
        bus.layer_rgb = {8'h00, 8'h00, 8'h00, 8'h1C};
        for (int i = 0; i < 3; i++) cycle(1'b0);
        n_cmp++; if (bus.rgb !== 12'hF00) begin n_err++; $display("FAIL pipe_hold rgb=%h exp=%h", bus.rgb, 12'hF00); end
    endtask

    task automatic test_priority;
        bus.layer_rgb = {8'h00, 8'h00, 8'h1C, 8'hE3};
        bus.layer_en  = 4'b0011;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h0F0) begin n_err++; $display("FAIL prio_key rgb=%h exp=%h", bus.rgb, 12'h0F0); end
        bus.layer_en = 4'b0010;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h0F0) begin n_err++; $display("FAIL prio_en1 rgb=%h exp=%h", bus.rgb, 12'h0F0); end
        bus.layer_rgb = {8'h03, 8'h00, 8'h1C, 8'hE0};
        bus.layer_en  = 4'b1101;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'hF00) begin n_err++; $display("FAIL prio_low rgb=%h exp=%h", bus.rgb, 12'hF00); end
        bus.layer_en = 4'b1000;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h00F) begin n_err++; $display("FAIL prio_l3 rgb=%h exp=%h", bus.rgb, 12'h00F); end
        bus.layer_rgb = {8'h00, 8'h00, 8'h00, 8'hE3};
        bus.layer_en  = 4'b0001;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL prio_allkey rgb=%h exp=%h", bus.rgb, 12'h000); end
    endtask

    task automatic test_background;
        bus.layer_en = 4'b0000;
        bus.bg_rgb   = 8'h1C;
        bus.vsync_in = 1'b1;
        cycle(1'b0);
        n_cmp++; if (bus.frame_start !== 1'b1) begin n_err++; $display("FAIL bg_fs_pulse fs=%b exp=1", bus.frame_start); end
        n_cmp++; if (bus.frame_cnt !== 8'd1) begin n_err++; $display("FAIL bg_cnt1 cnt=%0d exp=1", bus.frame_cnt); end
        cycle(1'b0);
        n_cmp++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL bg_fs_width fs=%b exp=0", bus.frame_start); end
        bus.vsync_in = 1'b0;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h0F0) begin n_err++; $display("FAIL bg_old rgb=%h exp=%h", bus.rgb, 12'h0F0); end
        bus.bg_rgb = 8'h03;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h0F0) begin n_err++; $display("FAIL bg_midframe rgb=%h exp=%h", bus.rgb, 12'h0F0); end
        bus.vsync_in = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h0F0) begin n_err++; $display("FAIL bg_rise_tick rgb=%h exp=%h", bus.rgb, 12'h0F0); end
        cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'h00F) begin n_err++; $display("FAIL bg_new rgb=%h exp=%h", bus.rgb, 12'h00F); end
        n_cmp++; if (bus.frame_cnt !== 8'd2) begin n_err++; $display("FAIL bg_cnt2 cnt=%0d exp=2", bus.frame_cnt); end
        bus.vsync_in = 1'b0;
        bus.bg_rgb   = 8'hE3;
        cycle(1'b0);
        bus.vsync_in = 1'b1;
        cycle(1'b0);
        bus.vsync_in = 1'b0;
        cycle(1'b1); cycle(1'b1);
        n_cmp++; if (bus.rgb !== 12'hF0F) begin n_err++; $display("FAIL bg_keycolor rgb=%h exp=%h", bus.rgb, 12'hF0F); end
    endtask

    task automatic test_blanking;
        bus.layer_rgb = {8'h00, 8'h00, 8'h00, 8'hFF};
        bus.layer_en  = 4'b0001;
        bus.video_on  = 1'b0;
        bus.hsync_in  = 1'b1;
        bus.vsync_in  = 1'b1;
        cycle(1'b1);
        n_cmp++; if (bus.hsync !== 1'b0 || bus.vsync !== 1'b0) begin n_err++; $display("FAIL sync_early h=%b v=%b exp=0/0", bus.hsync, bus.vsync); end
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        cycle(1'b1);
        n_cmp++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin n_err++; $display("FAIL sync_2tick h=%b v=%b exp=1/1", bus.hsync, bus.vsync); end
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL blank rgb=%h exp=%h", bus.rgb, 12'h000); end
        cycle(1'b0);
        n_cmp++; if (bus.hsync !== 1'b1) begin n_err++; $display("FAIL sync_hold h=%b exp=1", bus.hsync); end
        cycle(1'b1);
        n_cmp++; if (bus.hsync !== 1'b0 || bus.vsync !== 1'b0) begin n_err++; $display("FAIL sync_end h=%b v=%b exp=0/0", bus.hsync, bus.vsync); end
        bus.video_on = 1'b1;
    endtask

    task automatic test_reset;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        cycle(1'b1); cycle(1'b1);
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.rgb !== 12'h000) begin n_err++; $display("FAIL rst_rgb rgb=%h exp=%h", bus.rgb, 12'h000); end
        n_cmp++; if (bus.hsync !== 1'b0 || bus.vsync !== 1'b0) begin n_err++; $display("FAIL rst_sync h=%b v=%b exp=0/0", bus.hsync, bus.vsync); end
        n_cmp++; if (bus.frame_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt cnt=%0d exp=0", bus.frame_cnt); end
        n_cmp++; if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs fs=%b exp=0", bus.frame_start); end
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        cycle(1'b0);
        reset = 1'b1;
        cycle(1'b0);
    endtask

    task automatic test_frame_wrap;
        int pulses;
        pulses = 0;
        for (int f = 0; f < 257; f++) begin
            bus.vsync_in = 1'b1;
            cycle(1'b0);
            if (bus.frame_start === 1'b1) pulses++;
            if (f == 255) begin
                n_cmp++; if (bus.frame_cnt !== 8'd0) begin n_err++; $display("FAIL wrap_zero cnt=%0d exp=0", bus.frame_cnt); end
            end
            cycle(1'b0);
            if (bus.frame_start === 1'b1) pulses++;
            bus.vsync_in = 1'b0;
            cycle(1'b0);
            if (bus.frame_start === 1'b1) pulses++;
        end
        n_cmp++; if (bus.frame_cnt !== 8'd1) begin n_err++; $display("FAIL wrap_cnt cnt=%0d exp=1", bus.frame_cnt); end
        n_cmp++; if (pulses !== 257) begin n_err++; $display("FAIL wrap_pulses got=%0d exp=257", pulses); end
    endtask

    initial begin
        bus.pixel_tick = 1'b0;
        bus.video_on   = 1'b0;
        bus.hsync_in   = 1'b0;
        bus.vsync_in   = 1'b0;
        bus.layer_rgb  = '0;
        bus.layer_en   = '0;
        bus.bg_rgb     = '0;
        #1;
        n_cmp++; if (bus.rgb !== 12'h000 || bus.frame_cnt !== 8'd0) begin n_err++; $display("FAIL init rgb=%h cnt=%0d exp=000/0", bus.rgb, bus.frame_cnt); end
        cycle(1'b0); cycle(1'b0);
        reset = 1'b1;
        cycle(1'b0);
        test_pipeline();
        test_priority();
        test_background();
        test_blanking();
        test_reset();
        test_frame_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
